// File: rtl/int_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : int_arbiter
// Description : Interrupt front end for the CPU status unit. Synchronizes the
//               reset, NMI and IRQ pins, holds a maskable IRQ bank, latches
//               NMI falling edges and BRK requests, and presents at most one
//               of rst/nmi/brk/irq per cycle with fixed priority.
//               Optional macro INT_ARB_ROUND_ROBIN_EN selects round-robin
//               IRQ arbitration instead of lowest-index-wins.
// Revision    : 1.0 - initial release
// ============================================================================
module int_arbiter #(
    parameter int IRQ_SRCS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int RST_HOLD    = 4
) (
    input  logic                clk,
    input  logic                a_rst,
    input  logic                rst_pin_n,
    input  logic                nmi_pin_n,
    input  logic [IRQ_SRCS-1:0] irq_pin_n,
    input  logic                brk_req,
    input  logic                feed_ack,
    input  logic                nmi_ack,
    input  logic                irq_ack,
    input  logic                mask_we,
    input  logic [IRQ_SRCS-1:0] mask_wdata,
    output logic [IRQ_SRCS-1:0] mask_rdata,
    output logic                rst,
    output logic                nmi,
    output logic                brk,
    output logic                irq,
    output logic [2:0]          irq_id,
    output logic [IRQ_SRCS-1:0] irq_pending
);

    // Synchronizer bundle layout: {irq[IRQ_SRCS-1:0], nmi, rst}
    localparam int         c_SW   = IRQ_SRCS + 2;
    localparam logic [3:0] c_HOLD = 4'(RST_HOLD);

    localparam logic [1:0] S_RST  = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_IRQ  = 2'd2;

    logic [c_SW-1:0]     sync_q [SYNC_STAGES];
    logic                nmi_prev_q;
    logic                w_sync_rst_n;
    logic                w_sync_nmi_n;
    logic [IRQ_SRCS-1:0] w_sync_irq_n;
    logic                w_nmi_edge;

    logic [IRQ_SRCS-1:0] mask_q, mask_d;
    logic                nmi_pend_q, nmi_pend_d;
    logic                brk_pend_q, brk_pend_d;

    logic [1:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rst_q, rst_d;
    logic                nmi_q, nmi_d;
    logic                brk_q, brk_d;
    logic                irq_q, irq_d;
    logic [2:0]          irq_id_q, irq_id_d;

    logic [2:0]          w_sel_id;
    logic                w_sel_pend;

    assign w_sync_rst_n = sync_q[SYNC_STAGES-1][0];
    assign w_sync_nmi_n = sync_q[SYNC_STAGES-1][1];
    assign w_sync_irq_n = sync_q[SYNC_STAGES-1][c_SW-1:2];
    assign w_nmi_edge   = nmi_prev_q & ~w_sync_nmi_n;

    assign irq_pending  = ~w_sync_irq_n & mask_q;
    assign mask_rdata   = mask_q;
    assign rst          = rst_q;
    assign nmi          = nmi_q;
    assign brk          = brk_q;
    assign irq          = irq_q;
    assign irq_id       = irq_id_q;

    // Pin synchronizer chains plus the NMI edge-detect history flop
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
            nmi_prev_q <= 1'b1;
        end else begin
            sync_q[0] <= {irq_pin_n, nmi_pin_n, rst_pin_n};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            nmi_prev_q <= w_sync_nmi_n;
        end
    end

    // Pending latches: a new edge/request wins over a same-cycle clear
    always_comb begin
        nmi_pend_d = nmi_pend_q;
        brk_pend_d = brk_pend_q;
        mask_d     = mask_we ? mask_wdata : mask_q;
        if (!w_sync_rst_n) begin
            nmi_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else begin
            if (w_nmi_edge)          nmi_pend_d = 1'b1;
            else if (nmi_ack)        nmi_pend_d = 1'b0;
            if (brk_req)             brk_pend_d = 1'b1;
            else if (brk_q && feed_ack) brk_pend_d = 1'b0;
        end
    end

    // Pending and mask registers
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            mask_q     <= '0;
            nmi_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            nmi_pend_q <= nmi_pend_d;
            brk_pend_q <= brk_pend_d;
        end
    end

`ifdef INT_ARB_ROUND_ROBIN_EN
    logic [2:0] rr_ptr_q;

    // Last-served pointer, moved on every acknowledged IRQ
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst)                       rr_ptr_q <= 3'd0;
        else if (state_q == S_IRQ && irq_ack) rr_ptr_q <= irq_id_q;
    end

    // Wrap candidates first, then let the lowest index above the pointer win
    always_comb begin
        w_sel_id = 3'd0;
        for (int i = IRQ_SRCS-1; i >= 0; i--)
            if (irq_pending[i] && (3'(i) <= rr_ptr_q)) w_sel_id = 3'(i);
        for (int i = IRQ_SRCS-1; i >= 0; i--)
            if (irq_pending[i] && (3'(i) > rr_ptr_q)) w_sel_id = 3'(i);
    end
`else
    // Lowest pending index wins
    always_comb begin
        w_sel_id = 3'd0;
        for (int i = IRQ_SRCS-1; i >= 0; i--)
            if (irq_pending[i]) w_sel_id = 3'(i);
    end
`endif

    // Is the source currently being presented still requesting?
    always_comb begin
        w_sel_pend = 1'b0;
        for (int i = 0; i < IRQ_SRCS; i++)
            if (irq_id_q == 3'(i)) w_sel_pend = irq_pending[i];
    end

    // State, hold counter and registered request outputs
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q  <= S_RST;
            cnt_q    <= c_HOLD;
            rst_q    <= 1'b1;
            nmi_q    <= 1'b0;
            brk_q    <= 1'b0;
            irq_q    <= 1'b0;
            irq_id_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rst_q    <= rst_d;
            nmi_q    <= nmi_d;
            brk_q    <= brk_d;
            irq_q    <= irq_d;
            irq_id_q <= irq_id_d;
        end
    end

    // Next-state: synced reset pin overrides every state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!w_sync_rst_n) begin
            state_d = S_RST;
            cnt_d   = c_HOLD;
        end else begin
            case (state_q)
                S_RST: begin
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                    end
                end
                S_IDLE: begin
                    if (!nmi_pend_d && !brk_pend_d && (|irq_pending)) state_d = S_IRQ;
                end
                S_IRQ: begin
                    if (nmi_pend_d || irq_ack || !w_sel_pend) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_RST;
                    cnt_d   = c_HOLD;
                end
            endcase
        end
    end

    // Output select: one-hot by priority nmi > brk > irq, irq_id frozen in S_IRQ
    always_comb begin
        rst_d    = 1'b0;
        nmi_d    = 1'b0;
        brk_d    = 1'b0;
        irq_d    = 1'b0;
        irq_id_d = irq_id_q;
        if (!w_sync_rst_n) begin
            rst_d    = 1'b1;
            irq_id_d = 3'd0;
        end else begin
            case (state_q)
                S_RST:  rst_d = (state_d == S_RST);
                S_IDLE: begin
                    if (nmi_pend_d)        nmi_d = 1'b1;
                    else if (brk_pend_d)   brk_d = 1'b1;
                    else if (|irq_pending) begin
                        irq_d    = 1'b1;
                        irq_id_d = w_sel_id;
                    end
                end
                S_IRQ: begin
                    if (nmi_pend_d)                 nmi_d = 1'b1;
                    else if (!irq_ack && w_sel_pend) irq_d = 1'b1;
                end
                default: begin
                    rst_d    = 1'b1;
                    irq_id_d = 3'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_arbiter
// Description : Scoreboard bench for int_arbiter. A behavioural model predicts
//               the registered outputs for every clock edge and queues them; a
//               monitor pops and compares after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_arbiter;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int HOLD = 4;

    logic         clk = 1'b0;
    logic         a_rst, rst_pin_n, nmi_pin_n, brk_req, feed_ack, nmi_ack, irq_ack, mask_we;
    logic [N-1:0] irq_pin_n, mask_wdata, mask_rdata, irq_pending;
    logic         rst, nmi, brk, irq;
    logic [2:0]   irq_id;

    always #5 clk = ~clk;

    int_arbiter #(.IRQ_SRCS(N), .SYNC_STAGES(SYNC), .RST_HOLD(HOLD)) u_dut (
        .clk(clk), .a_rst(a_rst), .rst_pin_n(rst_pin_n), .nmi_pin_n(nmi_pin_n),
        .irq_pin_n(irq_pin_n), .brk_req(brk_req), .feed_ack(feed_ack),
        .nmi_ack(nmi_ack), .irq_ack(irq_ack), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .mask_rdata(mask_rdata), .rst(rst), .nmi(nmi),
        .brk(brk), .irq(irq), .irq_id(irq_id), .irq_pending(irq_pending)
    );

    typedef struct packed {
        logic         rst, nmi, brk, irq;
        logic [2:0]   id;
        logic [N-1:0] mask, pend;
    } exp_t;

    typedef enum int {P_NONE, P_RST, P_NMI, P_BRK, P_IRQ} pres_e;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 1'b0;

    // Reference model: what is being presented, plus the pending facts
    pres_e          m_pres;
    int             m_id, m_cnt, m_ptr;
    bit             m_nmi_p, m_brk_p;
    logic [N-1:0]   m_mask;
    logic [N+1:0]   m_hist[$];   // sampled pins {irq, nmi, rst}, newest first

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i <= SYNC; i++) m_hist.push_back('1);
        m_pres  = P_RST;
        m_id    = 0;
        m_cnt   = HOLD;
        m_ptr   = 0;
        m_nmi_p = 1'b0;
        m_brk_p = 1'b0;
        m_mask  = '0;
    endtask

    function automatic int pick(logic [N-1:0] p);
`ifdef INT_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) if (p[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
        for (int i = 0; i < N; i++) if (p[i]) return i;
`endif
        return 0;
    endfunction

    function automatic exp_t snapshot();
        exp_t         e;
        logic [N+1:0] s;
        s      = m_hist[SYNC-1];
        e.rst  = (m_pres == P_RST);
        e.nmi  = (m_pres == P_NMI);
        e.brk  = (m_pres == P_BRK);
        e.irq  = (m_pres == P_IRQ);
        e.id   = 3'(m_id);
        e.mask = m_mask;
        e.pend = ~s[N+1:2] & m_mask;
        return e;
    endfunction

    // One clock edge of the model, using the inputs the DUT is about to sample
    task automatic model_step();
        logic [N+1:0] s, pv;
        logic [N-1:0] pend;
        bit           nmi_fall;
        s        = m_hist[SYNC-1];
        pv       = m_hist[SYNC];
        nmi_fall = pv[1] && !s[1];
        pend     = ~s[N+1:2] & m_mask;
        if (m_pres == P_IRQ && irq_ack) m_ptr = m_id;
        if (!s[0]) begin
            m_nmi_p = 1'b0;
            m_brk_p = 1'b0;
            m_pres  = P_RST;
            m_cnt   = HOLD;
            m_id    = 0;
        end else begin
            m_nmi_p = nmi_fall || (m_nmi_p && !nmi_ack);
            m_brk_p = brk_req || (m_brk_p && !(m_pres == P_BRK && feed_ack));
            case (m_pres)
                P_RST: begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) m_pres = P_NONE;
                end
                P_IRQ: begin
                    if (m_nmi_p)                    m_pres = P_NMI;
                    else if (irq_ack || !pend[m_id]) m_pres = P_NONE;
                end
                default: begin
                    if (m_nmi_p)      m_pres = P_NMI;
                    else if (m_brk_p) m_pres = P_BRK;
                    else if (|pend) begin
                        m_pres = P_IRQ;
                        m_id   = pick(pend);
                    end else          m_pres = P_NONE;
                end
            endcase
        end
        if (mask_we) m_mask = mask_wdata;
        m_hist.push_front({irq_pin_n, nmi_pin_n, rst_pin_n});
        void'(m_hist.pop_back());
    endtask

    // Predict the next edge, queue it, and advance to the following negedge
    task automatic tick();
        if (!a_rst) model_reset();
        else        model_step();
        exp_q.push_back(snapshot());
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_mask(input logic [N-1:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        tick();
        mask_we    = 1'b0;
    endtask

    // Monitor: compare DUT outputs against the queued prediction after each edge
    initial begin : monitor
        exp_t e;
        exp_t got;
        int   cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() == 0) begin
                if (stim_done) break;
                n_cmp++;
                n_bad++;
                $display("FAIL queue cyc%0d: no prediction available, required one", cyc);
            end else begin
                e   = exp_q.pop_front();
                got = '{rst, nmi, brk, irq, irq_id, mask_rdata, irq_pending};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL outputs cyc%0d: got rst=%b nmi=%b brk=%b irq=%b id=%0d mask=%b pend=%b, required rst=%b nmi=%b brk=%b irq=%b id=%0d mask=%b pend=%b",
                             cyc, got.rst, got.nmi, got.brk, got.irq, got.id, got.mask, got.pend,
                             e.rst, e.nmi, e.brk, e.irq, e.id, e.mask, e.pend);
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    // Stimulus: directed scenarios followed by a randomized run
    initial begin : stimulus
        a_rst      = 1'b0;
        rst_pin_n  = 1'b1;
        nmi_pin_n  = 1'b1;
        irq_pin_n  = '1;
        brk_req    = 1'b0;
        feed_ack   = 1'b0;
        nmi_ack    = 1'b0;
        irq_ack    = 1'b0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        model_reset();
        ticks(3);

        // Reset release and hold window
        a_rst = 1'b1;
        ticks(8);

        // Two IRQ sources, acked twice
        set_mask(4'b0110);
        irq_pin_n = 4'b1001;
        ticks(4);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        ticks(4);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        ticks(2);
        irq_pin_n = '1;
        ticks(3);

        // NMI preempts IRQ 3, IRQ re-presents after nmi_ack
        set_mask(4'b1000);
        irq_pin_n = 4'b0111;
        ticks(4);
        nmi_pin_n = 1'b0;
        ticks(5);
        nmi_ack = 1'b1; tick(); nmi_ack = 1'b0;
        ticks(3);
        nmi_pin_n = 1'b1;
        irq_ack   = 1'b1; tick(); irq_ack = 1'b0;
        irq_pin_n = '1;
        ticks(3);

        // BRK held until feed_ack, re-request in the ack cycle keeps it
        brk_req = 1'b1; tick(); brk_req = 1'b0;
        ticks(5);
        feed_ack = 1'b1; tick(); feed_ack = 1'b0;
        ticks(2);
        brk_req = 1'b1; tick(); brk_req = 1'b0;
        ticks(2);
        feed_ack = 1'b1; brk_req = 1'b1; tick(); brk_req = 1'b0;
        ticks(2);
        feed_ack = 1'b0;
        ticks(2);

        // Masking the presented source withdraws the IRQ without an ack
        set_mask(4'b0001);
        irq_pin_n = 4'b1110;
        ticks(4);
        set_mask(4'b0000);
        ticks(4);
        irq_pin_n = '1;

        // Reset pin pulse while NMI pending: pending cleared, mask kept
        set_mask(4'b0101);
        nmi_pin_n = 1'b0;
        ticks(4);
        rst_pin_n = 1'b0; tick(); rst_pin_n = 1'b1;
        ticks(8);
        nmi_pin_n = 1'b1;
        ticks(3);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            int b;
            if ($urandom_range(0, 7) == 0) begin
                b = int'($urandom_range(0, N-1));
                irq_pin_n[b] = ~irq_pin_n[b];
            end
            if ($urandom_range(0, 5) == 0) nmi_pin_n = ~nmi_pin_n;
            rst_pin_n  = ($urandom_range(0, 149) != 0);
            brk_req    = ($urandom_range(0, 11) == 0);
            feed_ack   = ($urandom_range(0, 2) == 0);
            nmi_ack    = ($urandom_range(0, 3) == 0);
            irq_ack    = ($urandom_range(0, 3) == 0);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = N'($urandom);
            tick();
        end

        rst_pin_n = 1'b1;
        brk_req   = 1'b0;
        feed_ack  = 1'b0;
        nmi_ack   = 1'b0;
        irq_ack   = 1'b0;
        mask_we   = 1'b0;
        ticks(6);
        stim_done = 1'b1;
    end

endmodule
`default_nettype wire
